fifo_wr_ctrl: RTL
=================

# fifo_wr_ctrl

Parametrised write-side controller for the asynchronous FIFO, replacing the fixed-depth write pointer logic. It runs in the write clock domain and keeps the binary write address and the registered Gray write pointer. It computes full from the already-synchronised read pointer for any power-of-two depth, and adds a fill-level count, an almost-full threshold flag and a sticky overflow flag. It drives the dual-port memory write port and feeds the read-domain synchroniser.

## Interface
- MEM_DEPTH, 8: FIFO depth in entries; power of two, ≥ 4. AW = $clog2(MEM_DEPTH).
- AF_THRESH, MEM_DEPTH-2: almost-full assert level, 1 ≤ AF_THRESH ≤ MEM_DEPTH.
- W_CLK  in  1  write-domain clock; the block's single clock.
- W_RST  in  1  asynchronous, active-low reset.
- W_INC  in  1  write request for the current cycle.
- W_OVF_CLR  in  1  clears W_OVF.
- WQ2  in  AW+1  read pointer, Gray coded, already 2-flop synchronised into W_CLK.
- W_EN  out  1  memory write enable = W_INC & ~W_FULL (combinational).
- W_addr  out  AW  memory write address, the low AW bits of the binary pointer.
- W_ptr  out  AW+1  registered Gray write pointer, sent to the read-domain synchroniser.
- W_FULL  out  1  FIFO full (registered).
- W_ALMOST_FULL  out  1  level ≥ AF_THRESH (registered).
- W_LEVEL  out  AW+1  entries occupied, as seen from the write domain (registered).
- W_OVF  out  1  sticky: a write was attempted while full.

## Operation
- Binary pointer wbin is AW+1 bits. wbin_nx = wbin + W_EN, with natural modulo-2^(AW+1) wrap; the extra MSB is the lap bit.
- Gray conversion: wgray_nx = wbin_nx ^ (wbin_nx >> 1). W_ptr <= wgray_nx. W_ptr is a flop output and never glitches.
- Full: W_FULL <= (wgray_nx == {~WQ2[AW:AW-1], WQ2[AW-2:0]}). This is generic in AW, with no hard-coded bit indices.
- Level: rbin = Gray-to-binary(WQ2), where bit i is the XOR of WQ2[AW:i]. W_LEVEL <= wbin_nx − rbin, modulo 2^(AW+1); the range is 0..MEM_DEPTH.
- Almost full: W_ALMOST_FULL <= (wbin_nx − rbin) ≥ AF_THRESH.
- Overflow: W_OVF <= (W_INC & W_FULL) | (W_OVF & ~W_OVF_CLR). Set wins over a simultaneous clear.
- A write attempted while full is dropped:
  - W_EN is low;
  - the pointer holds;
  - no memory write occurs.
- Level, full and almost-full are pessimistic: the read pointer lags by the synchroniser latency, so the block never under-reports occupancy.

## Timing
- Reset (W_RST low, async): wbin=0, W_addr=0, W_ptr=0, W_FULL=0, W_ALMOST_FULL=0, W_LEVEL=0, W_OVF=0. W_EN follows W_INC (W_FULL=0).
- Release is synchronous to the next W_CLK edge. The first write is accepted on the first edge after release.
- Write accept: W_EN high during cycle n. Memory is written at edge n with the current W_addr. W_addr, W_ptr, W_LEVEL and W_FULL reflect the write after edge n (zero-cycle flag lag).
- Filling write: the write that fills the last entry raises W_FULL on the same edge that advances the pointer. A write in the next cycle is blocked.
- Full release: the first edge after WQ2 changes. W_FULL drops and W_LEVEL decreases on that edge.
- Simultaneous W_INC and WQ2 change: both take effect in one edge, so the level stays unchanged after one write plus one read.
- Wrap-around: wbin wraps from 2^(AW+1)−1 to 0, and the Gray pointer changes by exactly one bit.
- Reset mid-operation clears all state immediately, regardless of clock. The read side must be reset in the same window.

## Structure
- No shared package. AW and the Gray mask are local parameters derived from MEM_DEPTH.
- One sub-module, fifo_gray2bin #(WIDTH): a combinational Gray-to-binary converter, reused by the read-side controller.
- Binary-to-Gray stays inline as a single XOR expression.

## Test plan
All scenarios use MEM_DEPTH=8, AF_THRESH=6 and WQ2 held at 0 unless stated.
- Reset values: assert W_RST mid-burst -> all outputs 0 immediately, and after release the first W_INC gives W_addr=1, W_ptr=4'b0001.
- Fill to full: 8 consecutive writes -> W_LEVEL=6 and W_ALMOST_FULL=1 after the 6th, W_FULL=1 and W_LEVEL=8 after the 8th, W_ptr=4'b1100.
- Overflow: W_INC while full -> W_EN=0, W_addr is unchanged and W_OVF=1. Pulsing W_OVF_CLR clears it. Overflow and clear in the same cycle -> W_OVF stays 1.
- Drain release: with full set, WQ2 goes 0000→0001 -> W_FULL=0 and W_LEVEL=7 the next edge, and a following write re-asserts W_FULL.
- Wrap and simultaneity: stream 40 writes with WQ2 tracking 3 entries behind -> W_LEVEL stays constant at 3, W_FULL never asserts, and W_ptr changes by exactly one bit per write, including the 15→0 wrap.
- Generics: rerun the fill/full test at MEM_DEPTH=4 and MEM_DEPTH=64 -> full asserts after exactly MEM_DEPTH writes.

Source files
------------

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter.
// Shared by the write- and read-side FIFO pointer controllers.
module fifo_gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of every Gray bit at or above it.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bin[gi] = ^gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer controller for the asynchronous FIFO.
// Provides full, fill level, almost-full and sticky overflow from the synchronised read pointer.
module fifo_wr_ctrl #(
  parameter int MEM_DEPTH = 8,
  parameter int AF_THRESH = MEM_DEPTH - 2,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic          W_CLK,
  input  logic          W_RST,
  input  logic          W_INC,
  input  logic          W_OVF_CLR,
  input  logic [AW:0]   WQ2,
  output logic          W_EN,
  output logic [AW-1:0] W_addr,
  output logic [AW:0]   W_ptr,
  output logic          W_FULL,
  output logic          W_ALMOST_FULL,
  output logic [AW:0]   W_LEVEL,
  output logic          W_OVF
);

  // Full means the write pointer is one lap ahead: in Gray code, the top two bits inverted.
  localparam logic [AW:0] GRAY_MASK = {2'b11, {(AW-1){1'b0}}};
  localparam logic [AW:0] AF_LVL    = (AW+1)'(AF_THRESH);

  logic [AW:0] wbin_reg;
  logic [AW:0] wbin_next;
  logic [AW:0] wgray_next;
  logic [AW:0] rbin;
  logic [AW:0] level_next;

  assign W_EN       = W_INC & ~W_FULL;
  assign wbin_next  = wbin_reg + (AW+1)'(W_EN);
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign level_next = wbin_next - rbin;
  assign W_addr     = wbin_reg[AW-1:0];

  fifo_gray2bin #(
    .WIDTH (AW + 1)
  ) u_rptr_g2b (
    .gray (WQ2),
    .bin  (rbin)
  );

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin_reg      <= '0;
      W_ptr         <= '0;
      W_FULL        <= 1'b0;
      W_ALMOST_FULL <= 1'b0;
      W_LEVEL       <= '0;
      W_OVF         <= 1'b0;
    end else begin
      wbin_reg      <= wbin_next;
      W_ptr         <= wgray_next;
      W_FULL        <= (wgray_next == (WQ2 ^ GRAY_MASK));
      W_ALMOST_FULL <= (level_next >= AF_LVL);
      W_LEVEL       <= level_next;
      // A dropped write sets the flag even when a clear arrives in the same cycle.
      W_OVF         <= (W_INC & W_FULL) | (W_OVF & ~W_OVF_CLR);
    end
  end

endmodule
